// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// Defines the default operand width, ID width helper and slot state.
package adder_share_pkg;

    localparam int N_DEFAULT = 12;

    // Width of a requester index; never narrower than one bit.
    function automatic int ID_W(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/adder_12bit.sv
// Combinational ripple-carry adder, sum = (a + b) mod 2^N.
// Ports: a, b operands; sum result (carry-out dropped).
module adder_12bit #(
    parameter int N = 12
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    logic carry;

    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter searching upward from ptr.
// Ports: req vector, en, ptr in; one-hot gnt, gnt_idx, gnt_vld out.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_vld
);

    int            idx;
    logic [IW-1:0] sel;

    // Walk offsets from farthest to nearest so the requester
    // closest to ptr (in wrap order) is the one left standing.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = idx[IW-1:0];
            if (en && req[sel]) begin
                gnt      = '0;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one adder among NUM_REQ requesters with a single result slot.
// Ports: req_valid/ready/a/b in, rsp_valid/ready/sum/id out, busy, op_count.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int N       = N_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*N-1:0]        req_a,
    input  logic [NUM_REQ*N-1:0]        req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [N-1:0]                rsp_sum,
    output logic [ID_W(NUM_REQ)-1:0]    rsp_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            op_count
);

    localparam int IW = ID_W(NUM_REQ);

    slot_state_t        state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      id_q, id_d;
    logic [N-1:0]       sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic               slot_free;
    logic               rsp_hs;
    logic [N-1:0]       op_a, op_b, add_s;

    assign slot_free = (state_q == EMPTY) | rsp_ready;
    assign rsp_hs    = (state_q == FULL) & rsp_ready;

    // Gating with rst keeps req_ready low during reset.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req     (req_valid),
        .en      (slot_free & ~rst),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign op_a = req_a[gnt_idx*N +: N];
    assign op_b = req_b[gnt_idx*N +: N];

    adder_12bit #(
        .N   (N)
    ) u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (add_s)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        if (gnt_vld) begin
            state_d = FULL;
            sum_d   = add_s;
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_hs) begin
            state_d = EMPTY;
        end
        if (rsp_hs) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = (state_q == FULL);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign op_count  = cnt_q;
    assign busy      = rsp_valid | (|req_valid);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter (NUM_REQ=4, N=12).
// Expected results are queued at accept and compared at handshake.
module tb_adder_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [47:0] req_a = '0;
    logic [47:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [11:0] rsp_sum;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [15:0] op_count;

    typedef struct {
        logic [1:0]  id;
        logic [11:0] sum;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = '0;

    adder_share_arbiter #(
        .NUM_REQ   (4),
        .N         (12),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] model_add(logic [11:0] a, logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[11:0];
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e.id  = 'x;
        e.sum = 'x;
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic set_req(int i, logic [11:0] a, logic [11:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*12 +: 12]  = a;
        req_b[i*12 +: 12]  = b;
    endtask

    // Record accepts and handshakes for this cycle, then advance.
    task automatic tick();
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i])
                sb.push_back('{id: 2'(i),
                    sum: model_add(req_a[i*12 +: 12], req_b[i*12 +: 12])});
        end
        if (rsp_valid && rsp_ready) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_ready: got %b want 0000", req_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        sb.delete();
        exp_cnt = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", rsp_valid);
        end
        n_cmp++;
        if (rsp_sum !== 12'h000 || rsp_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_sum_id: got %h/%0d want 000/0", rsp_sum, rsp_id);
        end
        n_cmp++;
        if (op_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d want 0", op_count);
        end
        @(posedge clk);
    endtask

    task automatic test_single();
        exp_t e;
        @(negedge clk);
        set_req(2, 12'h123, 12'h456);
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 12'h579 || rsp_id !== 2'd2) begin
            n_bad++;
            $display("FAIL single_rsp: got v%b %h id%0d want v1 579 id2",
                     rsp_valid, rsp_sum, rsp_id);
        end
        if (rsp_valid && rsp_ready) begin
            e = pop_exp();
            n_cmp++;
            if (rsp_sum !== e.sum || rsp_id !== e.id) begin
                n_bad++;
                $display("FAIL single_sb: got %h/%0d want %h/%0d",
                         rsp_sum, rsp_id, e.sum, e.id);
            end
        end
        tick();
        @(negedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || op_count !== 16'd1 || op_count !== exp_cnt) begin
            n_bad++;
            $display("FAIL single_count: got v%b cnt%0d want v0 cnt1",
                     rsp_valid, op_count);
        end
        @(posedge clk);
    endtask

    task automatic test_wrap();
        exp_t e;
        @(negedge clk);
        set_req(1, 12'hFFF, 12'h001);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL wrap_ready: got %b want 0010", req_ready);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (c == 0) set_req(1, 12'h800, 12'h800);
            else req_valid = '0;
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 12'h000) begin
                n_bad++;
                $display("FAIL wrap_sum%0d: got v%b %h want v1 000",
                         c, rsp_valid, rsp_sum);
            end
            if (rsp_valid && rsp_ready) begin
                e = pop_exp();
                n_cmp++;
                if (rsp_sum !== e.sum || rsp_id !== e.id) begin
                    n_bad++;
                    $display("FAIL wrap_sb%0d: got %h/%0d want %h/%0d",
                             c, rsp_sum, rsp_id, e.sum, e.id);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   j;
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            set_req(i, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 1 && k <= 4) begin
                j = (k - 1) % 4;
                set_req(j, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
            end
            if (k == 5) req_valid = '0;
            #1;
            if (k < 5) begin
                n_cmp++;
                if (req_ready !== (4'b0001 << (k % 4))) begin
                    n_bad++;
                    $display("FAIL rr_grant%0d: got %b want %b",
                             k, req_ready, 4'b0001 << (k % 4));
                end
            end
            if (k >= 1) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4)) begin
                    n_bad++;
                    $display("FAIL rr_id%0d: got v%b id%0d want v1 id%0d",
                             k, rsp_valid, rsp_id, (k - 1) % 4);
                end
            end
            if (rsp_valid && rsp_ready) begin
                e = pop_exp();
                n_cmp++;
                if (rsp_sum !== e.sum || rsp_id !== e.id) begin
                    n_bad++;
                    $display("FAIL rr_sb%0d: got %h/%0d want %h/%0d",
                             k, rsp_sum, rsp_id, e.sum, e.id);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        @(negedge clk);
        req_valid = '0;
        set_req(0, 12'h0F0, 12'h00F);
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL bp_first: got %b want 0001", req_ready);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = '0;
            set_req(1, 12'h321, 12'h0AB);
            #1;
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready);
            end
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 12'h0FF || rsp_id !== 2'd0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got v%b %h/%0d want v1 0ff/0",
                         c, rsp_valid, rsp_sum, rsp_id);
            end
            tick();
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_release: got %b want 0010", req_ready);
        end
        e = pop_exp();
        n_cmp++;
        if (rsp_sum !== e.sum || rsp_id !== e.id) begin
            n_bad++;
            $display("FAIL bp_sb0: got %h/%0d want %h/%0d",
                     rsp_sum, rsp_id, e.sum, e.id);
        end
        tick();
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 12'h3CC) begin
            n_bad++;
            $display("FAIL bp_b2b: got v%b %h/%0d want v1 3cc/1",
                     rsp_valid, rsp_sum, rsp_id);
        end
        e = pop_exp();
        n_cmp++;
        if (rsp_sum !== e.sum || rsp_id !== e.id) begin
            n_bad++;
            $display("FAIL bp_sb1: got %h/%0d want %h/%0d",
                     rsp_sum, rsp_id, e.sum, e.id);
        end
        tick();
        @(negedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || op_count !== exp_cnt) begin
            n_bad++;
            $display("FAIL bp_count: got v%b cnt%0d want v0 cnt%0d",
                     rsp_valid, op_count, exp_cnt);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        @(negedge clk);
        set_req(3, 12'h555, 12'h111);
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL mid_grant: got %b want 1000", req_ready);
        end
        tick();
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_rst_ready: got %b want 0000", req_ready);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
        rsp_ready = 1'b1;
        set_req(0, 12'h00A, 12'h005);
        set_req(3, 12'h100, 12'h200);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_cleared: got v%b cnt%0d want v0 cnt0",
                     rsp_valid, op_count);
        end
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL mid_ptr: got %b want 0001", req_ready);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 4'b1000 : 4'b0000;
            #1;
            e = pop_exp();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_sum !== e.sum || rsp_id !== e.id) begin
                n_bad++;
                $display("FAIL mid_sb%0d: got v%b %h/%0d want v1 %h/%0d",
                         c, rsp_valid, rsp_sum, rsp_id, e.sum, e.id);
            end
            tick();
        end
        @(negedge clk); #1;
        n_cmp++;
        if (sb.size() != 0 || rsp_valid !== 1'b0 || op_count !== 16'd2) begin
            n_bad++;
            $display("FAIL mid_drain: got q%0d v%b cnt%0d want q0 v0 cnt2",
                     sb.size(), rsp_valid, op_count);
        end
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
